// File: rtl/rgb_binarize_if.sv
// Pixel-in / binary-pixel-out bus for rgb_binarize; the master drives the
// RGB565 stream and threshold strobe, the slave returns the binarized stream.
interface rgb_binarize_if;
  logic [15:0] din;
  logic        din_vld;
  logic        din_sop;
  logic        din_eop;
  logic        thresh_wr;
  logic [7:0]  thresh_in;
  logic        dout;
  logic        dout_vld;
  logic        dout_sop;
  logic        dout_eop;
  logic        frame_err;

  modport master (
    output din, din_vld, din_sop, din_eop, thresh_wr, thresh_in,
    input  dout, dout_vld, dout_sop, dout_eop, frame_err
  );

  modport slave (
    input  din, din_vld, din_sop, din_eop, thresh_wr, thresh_in,
    output dout, dout_vld, dout_sop, dout_eop, frame_err
  );
endinterface

// File: rtl/rgb_binarize.sv
// RGB565 -> 8-bit luma -> 1-bit threshold, 3-stage pipeline, frame policing.
// Latency 3 registers; no backpressure, one pixel per clock.
module rgb_binarize #(
  parameter int unsigned IMG_W          = 640,
  parameter int unsigned IMG_H          = 480,
  parameter logic [7:0]  THRESH_DEFAULT = 8'd128,
  parameter bit          INVERT         = 1'b0
) (
  input logic          clk,
  input logic          rst,
  rgb_binarize_if.slave bus
);

  localparam int unsigned PIX_TOTAL = IMG_W * IMG_H;
  localparam int          CNT_W     = $clog2(PIX_TOTAL + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(PIX_TOTAL);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PIX_TOTAL - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic {IDLE, IN_FRAME} state_t;

  state_t           state;
  logic [CNT_W-1:0] pix_cnt;
  logic             frame_err_q;
  logic [7:0]       thr_pending;
  logic [7:0]       thr_active;
  logic [7:0]       thr_sel;
  logic             accept;
  logic             start;

  logic [7:0]  r8, g8, b8;
  logic [15:0] p_r, p_g, p_b;
  logic [7:0]  thr1, thr2;
  logic [7:0]  y2;
  logic [7:0]  luma;
  logic        vld1, sop1, eop1;
  logic        vld2, sop2, eop2;
  logic        dout_q, dout_vld_q, dout_sop_q, dout_eop_q;

  // A pixel carries the threshold of its own frame down the pipe, so a new
  // frame starting right behind an eop cannot re-threshold the old tail.
  always_comb begin
    accept  = bus.din_vld & (bus.din_sop | (state == IN_FRAME));
    start   = accept & bus.din_sop;
    thr_sel = thr_active;
    if (start) thr_sel = bus.thresh_wr ? bus.thresh_in : thr_pending;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pix_cnt     <= '0;
      frame_err_q <= 1'b0;
      thr_pending <= THRESH_DEFAULT;
      thr_active  <= THRESH_DEFAULT;
    end else begin
      frame_err_q <= 1'b0;
      if (bus.thresh_wr) thr_pending <= bus.thresh_in;
      if (start)         thr_active  <= thr_sel;
      if (bus.din_vld) begin
        if (bus.din_sop) begin
          if (bus.din_eop) begin
            state       <= IDLE;
            pix_cnt     <= '0;
            frame_err_q <= (state == IN_FRAME) || (PIX_TOTAL != 1);
          end else begin
            state       <= IN_FRAME;
            pix_cnt     <= CNT_ONE;
            frame_err_q <= (state == IN_FRAME);
          end
        end else if (state == IN_FRAME) begin
          if (bus.din_eop) begin
            state       <= IDLE;
            pix_cnt     <= '0;
            frame_err_q <= (pix_cnt != CNT_LAST);
          end else if (pix_cnt == CNT_FULL) begin
            // overrun: this pixel still goes out, the rest wait for a sop
            state       <= IDLE;
            pix_cnt     <= '0;
            frame_err_q <= 1'b1;
          end else begin
            pix_cnt <= pix_cnt + CNT_ONE;
          end
        end else begin
          frame_err_q <= 1'b1;
        end
      end
    end
  end

  assign r8   = {bus.din[15:11], bus.din[15:13]};
  assign g8   = {bus.din[10:5],  bus.din[10:9]};
  assign b8   = {bus.din[4:0],   bus.din[4:2]};
  assign luma = 8'((p_r + p_g + p_b) >> 8);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld1 <= 1'b0; sop1 <= 1'b0; eop1 <= 1'b0;
      vld2 <= 1'b0; sop2 <= 1'b0; eop2 <= 1'b0;
      p_r  <= '0;   p_g  <= '0;   p_b  <= '0;
      thr1 <= '0;   thr2 <= '0;   y2   <= '0;
      dout_q     <= 1'b0;
      dout_vld_q <= 1'b0;
      dout_sop_q <= 1'b0;
      dout_eop_q <= 1'b0;
    end else begin
      vld1 <= accept;
      sop1 <= accept & bus.din_sop;
      eop1 <= accept & bus.din_eop;
      p_r  <= 16'(r8) * 16'd77;
      p_g  <= 16'(g8) * 16'd150;
      p_b  <= 16'(b8) * 16'd29;
      thr1 <= thr_sel;

      vld2 <= vld1;
      sop2 <= sop1;
      eop2 <= eop1;
      y2   <= luma;
      thr2 <= thr1;

      dout_vld_q <= vld2;
      dout_sop_q <= sop2;
      dout_eop_q <= eop2;
      if (vld2) dout_q <= (y2 >= thr2) ^ INVERT;
    end
  end

  assign bus.dout      = dout_q;
  assign bus.dout_vld  = dout_vld_q;
  assign bus.dout_sop  = dout_sop_q;
  assign bus.dout_eop  = dout_eop_q;
  assign bus.frame_err = frame_err_q;

endmodule
